sram_arb_ctrl: RTL and testbench

Two-requester arbiter and sequencer for one single-port SRAM macro wrapper: address, chip enable, write enable, per-bit write mask, write data in, registered read data out with 1-cycle latency. It clears the whole array after reset or on request, then grants the macro port round-robin between two valid/ready requesters. It returns read data to the owning requester with a tagged response valid. It sits between cache/TCM request logic and the generated SRAM wrappers.

---
 rtl/sram_ctrl_pkg.sv | 12 +
 rtl/rr_arb2.sv | 33 +++
 rtl/sram_arb_ctrl.sv | 121 ++++++++++++
 tb/tb_sram_arb_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the single-port SRAM arbiter/sequencer.
package sram_ctrl_pkg;

   typedef enum logic {ST_INIT, ST_RUN} ctrl_state_e;

   localparam int unsigned NUM_REQ = 2;

   function automatic int unsigned depth_f(input int unsigned aw);
      return 32'd1 << aw;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: combinational one-hot grant, pointer moves
// to the other requester whenever a grant is taken.
module rr_arb2
   import sram_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] gnt,
   output logic               gnt_idx
);

   logic r_ptr;

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = r_ptr ? 2'b10 : 2'b01;
      end
   end

   assign gnt_idx = gnt[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= 1'b0;
      end else if (advance) begin
         r_ptr <= ~gnt_idx;
      end
   end

endmodule

// File: rtl/sram_arb_ctrl.sv
// Arbiter and sequencer for one single-port SRAM macro: array clear after reset
// or on request, then round-robin service of two requesters with tagged reads.
module sram_arb_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned AW      = 10,
   parameter int unsigned DW      = 32,
   parameter bit          INIT_EN = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                init_req,
   output logic                init_done,
   input  logic [NUM_REQ-1:0]  req_valid,
   output logic [NUM_REQ-1:0]  req_ready,
   input  logic [NUM_REQ-1:0]  req_we,
   input  logic [2*AW-1:0]     req_addr,
   input  logic [2*DW-1:0]     req_wdata,
   input  logic [2*DW-1:0]     req_wmask,
   output logic [NUM_REQ-1:0]  rsp_valid,
   output logic [DW-1:0]       rsp_rdata,
   output logic                mem_cs,
   output logic                mem_we,
   output logic [AW-1:0]       mem_addr,
   output logic [DW-1:0]       mem_wdata,
   output logic [DW-1:0]       mem_wmask,
   input  logic [DW-1:0]       mem_rdata
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(depth_f(AW) - 1);

   ctrl_state_e r_state, w_state_nxt;
   logic [AW-1:0] r_cnt, w_cnt_nxt;
   logic r_rsp_pend;
   logic r_rsp_idx;

   logic [NUM_REQ-1:0] w_arb_req;
   logic [NUM_REQ-1:0] w_gnt;
   logic w_gnt_idx;
   logic w_grant;
   logic w_sel_we;

   // Gating with rst_n keeps every macro/handshake output quiet while reset is held.
   assign w_arb_req = (rst_n && r_state == ST_RUN) ? req_valid : '0;
   assign w_grant   = |w_gnt;
   assign w_sel_we  = w_gnt_idx ? req_we[1] : req_we[0];

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (w_arb_req),
      .advance (w_grant),
      .gnt     (w_gnt),
      .gnt_idx (w_gnt_idx)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_INIT: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == LAST_ADDR) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (init_req) begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_INIT;
            end
         end
         default: begin
            w_state_nxt = ST_INIT;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      mem_cs    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wmask = '0;
      if (rst_n && r_state == ST_INIT) begin
         mem_cs    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = r_cnt;
         mem_wmask = '1;
      end else if (w_grant) begin
         mem_cs    = 1'b1;
         mem_we    = w_sel_we;
         mem_addr  = w_gnt_idx ? req_addr[AW +: AW] : req_addr[0 +: AW];
         mem_wdata = w_gnt_idx ? req_wdata[DW +: DW] : req_wdata[0 +: DW];
         if (w_sel_we) begin
            mem_wmask = w_gnt_idx ? req_wmask[DW +: DW] : req_wmask[0 +: DW];
         end
      end
   end

   assign req_ready = w_gnt;
   assign init_done = (r_state == ST_RUN);
   assign rsp_valid = r_rsp_pend ? (r_rsp_idx ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_rdata = mem_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= INIT_EN ? ST_INIT : ST_RUN;
         r_cnt      <= '0;
         r_rsp_pend <= 1'b0;
         r_rsp_idx  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_rsp_pend <= w_grant & ~w_sel_we;
         r_rsp_idx  <= w_gnt_idx;
      end
   end

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Scoreboard bench for sram_arb_ctrl with a behavioural 16x32 SRAM macro model.
module tb_sram_arb_ctrl;

   localparam int unsigned AW = 4;
   localparam int unsigned DW = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            init_req = 1'b0;
   logic            init_done;
   logic [1:0]      req_valid = '0;
   logic [1:0]      req_ready;
   logic [1:0]      req_we = '0;
   logic [2*AW-1:0] req_addr = '0;
   logic [2*DW-1:0] req_wdata = '0;
   logic [2*DW-1:0] req_wmask = '0;
   logic [1:0]      rsp_valid;
   logic [DW-1:0]   rsp_rdata;
   logic            mem_cs;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW-1:0]   mem_wmask;
   logic [DW-1:0]   mem_rdata = '0;

   typedef struct {
      logic [1:0]  vld;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int n_tests = 0;
   int n_fail = 0;
   int cyc = 0;

   logic [DW-1:0] mem [16] = '{default: 32'hA5A5_A5A5};

   sram_arb_ctrl #(.AW(AW), .DW(DW), .INIT_EN(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .init_req  (init_req),
      .init_done (init_done),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wmask (req_wmask),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .mem_cs    (mem_cs),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wmask (mem_wmask),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_cs) begin
         if (mem_we) mem[mem_addr] <= (mem[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
         else        mem_rdata <= mem[mem_addr];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every presented response must match the oldest expected one.
   always @(negedge clk) begin
      if (rst_n && rsp_valid != 2'b00) begin
         if (q.size() == 0) begin
            chk("unexpected_rsp", {62'd0, rsp_valid}, 64'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("rsp_valid", {62'd0, rsp_valid}, {62'd0, e.vld});
            chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.data});
            chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_rsp(input int idx, input logic [31:0] data);
      exp_t e;
      e.vld  = (idx == 1) ? 2'b10 : 2'b01;
      e.data = data;
      e.cyc  = cyc + 1;
      q.push_back(e);
   endtask

   // Single-requester access; leaves time just after the granting edge.
   task automatic do_req(input int idx, input logic we, input logic [3:0] addr,
                         input logic [31:0] wdata, input logic [31:0] wmask,
                         input logic [31:0] exp_rd);
      req_valid = (idx == 1) ? 2'b10 : 2'b01;
      req_we[idx] = we;
      req_addr[idx*AW +: AW] = addr;
      req_wdata[idx*DW +: DW] = wdata;
      req_wmask[idx*DW +: DW] = wmask;
      @(negedge clk);
      chk("req_ready", {62'd0, req_ready}, {62'd0, req_valid});
      chk("mem_addr", {60'd0, mem_addr}, {60'd0, addr});
      if (!we) expect_rsp(idx, exp_rd);
      tick();
      req_valid = 2'b00;
   endtask

   // Expects a full clear starting now; optionally holds requests and init_req.
   task automatic check_clear(input logic hold);
      req_valid = hold ? 2'b11 : 2'b00;
      init_req  = hold;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("clr_ctl", {60'd0, mem_cs, mem_we, req_ready, init_done},
             {60'd0, 1'b1, 1'b1, 2'b00, 1'b0});
         chk("clr_addr", {60'd0, mem_addr}, 64'(i));
         chk("clr_data", {mem_wdata, mem_wmask}, {32'h0, 32'hFFFF_FFFF});
      end
      req_valid = 2'b00;
      init_req  = 1'b0;
      @(negedge clk);
      chk("clr_done", {62'd0, init_done, mem_cs}, {62'd0, 1'b1, 1'b0});
      tick();
   endtask

   initial begin
      #1;
      @(negedge clk);
      chk("rst_outs", {57'd0, mem_cs, mem_we, req_ready, rsp_valid, init_done},
          64'd0);
      chk("rst_bus", {28'd0, mem_addr, mem_wdata}, 64'd0);
      chk("rst_mask", {32'd0, mem_wmask}, 64'd0);
      tick();
      rst_n = 1'b1;
      check_clear(1'b0);

      do_req(0, 1'b0, 4'd5, 32'h0, 32'h0, 32'h0000_0000);
      do_req(0, 1'b1, 4'd3, 32'hDEAD_BEEF, 32'hFFFF_0000, 32'h0);
      do_req(0, 1'b0, 4'd3, 32'h0, 32'h0, 32'hDEAD_0000);
      do_req(1, 1'b1, 4'd1, 32'h1111_1111, 32'hFFFF_FFFF, 32'h0);
      do_req(1, 1'b1, 4'd2, 32'h2222_2222, 32'hFFFF_FFFF, 32'h0);

      // Contention: pointer is at requester 0 here.
      req_valid = 2'b11;
      req_we    = 2'b00;
      req_addr  = {4'd2, 4'd1};
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("rr_ready", {62'd0, req_ready}, (k % 2 == 1) ? 64'd2 : 64'd1);
         expect_rsp(k % 2, (k % 2 == 1) ? 32'h2222_2222 : 32'h1111_1111);
         tick();
      end
      req_valid = 2'b00;

      do_req(1, 1'b1, 4'd7, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0);
      do_req(0, 1'b0, 4'd7, 32'h0, 32'h0, 32'h1234_5678);

      // init_req together with a granted read; init_req held through the clear.
      init_req = 1'b1;
      do_req(0, 1'b0, 4'd7, 32'h0, 32'h0, 32'h1234_5678);
      check_clear(1'b1);
      do_req(1, 1'b0, 4'd7, 32'h0, 32'h0, 32'h0000_0000);
      do_req(0, 1'b0, 4'd3, 32'h0, 32'h0, 32'h0000_0000);

      // Async reset mid-clear at address 9.
      init_req = 1'b1;
      tick();
      init_req = 1'b0;
      repeat (9) tick();
      chk("pre_rst_addr", {60'd0, mem_addr}, 64'd9);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_outs", {57'd0, mem_cs, mem_we, req_ready, rsp_valid, init_done},
          64'd0);
      chk("mid_rst_bus", {mem_wmask, mem_wdata}, 64'd0);
      chk("mid_rst_addr", {60'd0, mem_addr}, 64'd0);
      tick();
      rst_n = 1'b1;
      check_clear(1'b0);

      // Reset while a read response is showing: response must vanish.
      req_valid = 2'b10;
      req_we    = 2'b00;
      req_addr  = {4'd5, 4'd0};
      tick();
      req_valid = 2'b00;
      chk("rsp_before_rst", {62'd0, rsp_valid}, 64'd2);
      #1 rst_n = 1'b0;
      #1;
      chk("rsp_dropped", {62'd0, rsp_valid}, 64'd0);
      tick();
      tick();

      chk("sb_empty", 64'(q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation timed out at cycle %0d", cyc);
      $fatal(1);
   end

endmodule
